// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter and sequencer for a negedge-sampled, registered-read data RAM.
// Defining RAM_ARB_FIXED_PRIO_EN gives port A fixed priority; otherwise arbitration is round-robin.
module ram_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          busy,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  state_t state, next;
  logic owner, last_grant, we_l, gnt_b, start;
`ifdef RAM_ARB_FIXED_PRIO_EN
  assign gnt_b = b_req & ~a_req;
`else
  assign gnt_b = b_req & (~a_req | ~last_grant);
`endif
  assign start = (state == IDLE) & (a_req | b_req);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state == IDLE ? (start ? ACCESS : IDLE) : state == ACCESS ? ACK : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      we_l       <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      a_rdata    <= '0;
      b_rdata    <= '0;
    end else begin
      if (start) begin
        owner      <= gnt_b;
        last_grant <= gnt_b;
        we_l       <= gnt_b ? b_we : a_we;
        ram_addr   <= gnt_b ? b_addr : a_addr;
        ram_din    <= gnt_b ? b_wdata : a_wdata;
      end
      if (state == ACCESS && !we_l && owner) b_rdata <= ram_dout;
      if (state == ACCESS && !we_l && !owner) a_rdata <= ram_dout;
    end
  end
  // Write enable is gated by state so an async reset removes it immediately.
  always_comb begin
    ram_we = (state == ACCESS) & we_l;
    busy   = state != IDLE;
    a_ack  = (state == ACK) & ~owner;
    b_ack  = (state == ACK) & owner;
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with a behavioural negedge RAM.
module tb_ram_arbiter;
  logic        clk = 0, rst;
  logic        a_req, a_we, b_req, b_we;
  logic [9:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic        a_ack, b_ack, busy, ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din, ram_dout;
  logic [31:0] mem [1024];
  logic [3:0]  seq;
  logic        exp_b;
  int n = 0, nf = 0;

  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .busy(busy), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n++;
    assert (got === exp) else begin
      nf++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[1] = 32'h11111111;
    mem[2] = 32'h22222222;
    mem[10'h010] = 32'hAAAA0010;
    mem[10'h020] = 32'hBBBB0020;
    ram_dout = 32'h0;
    rst = 1; a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    step(); step();
    chk("rst_aack", a_ack, 0);
    chk("rst_back", b_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_din", ram_din, 0);
    chk("rst_ardata", a_rdata, 0);
    chk("rst_brdata", b_rdata, 0);
    rst = 0;
    // reset in the middle of an A write
    a_req = 1; a_we = 1; a_addr = 10'd5; a_wdata = 32'h12345678;
    step();
    chk("t1_busy", busy, 1);
    chk("t1_we", ram_we, 1);
    chk("t1_addr", ram_addr, 5);
    #2 rst = 1;
    #1;
    chk("t1_we_rst", ram_we, 0);
    chk("t1_busy_rst", busy, 0);
    chk("t1_aack_rst", a_ack, 0);
    a_req = 0; a_we = 0;
    step();
    rst = 0;
    chk("t1_nowrite", mem[5], 0);
    chk("t1_idle", busy, 0);
    // A write then read of 0x3FF
    a_req = 1; a_we = 1; a_addr = 10'h3FF; a_wdata = 32'hDEADBEEF;
    step();
    chk("t2_w_we", ram_we, 1);
    chk("t2_w_addr", ram_addr, 10'h3FF);
    chk("t2_w_din", ram_din, 32'hDEADBEEF);
    chk("t2_w_ack0", a_ack, 0);
    step();
    chk("t2_w_ack", a_ack, 1);
    chk("t2_w_weoff", ram_we, 0);
    chk("t2_w_back", b_ack, 0);
    a_req = 0;
    step();
    chk("t2_w_ackoff", a_ack, 0);
    chk("t2_w_busy", busy, 0);
    chk("t2_mem", mem[10'h3FF], 32'hDEADBEEF);
    a_req = 1; a_we = 0;
    step();
    chk("t2_r_we", ram_we, 0);
    step();
    chk("t2_r_ack", a_ack, 1);
    chk("t2_r_data", a_rdata, 32'hDEADBEEF);
    chk("t2_r_brdata", b_rdata, 0);
    a_req = 0;
    step();
    // continuous contention, A reads 0x001, B reads 0x002
`ifdef RAM_ARB_FIXED_PRIO_EN
    seq = 4'b0000;
`else
    seq = 4'b0101;
`endif
    a_req = 1; a_addr = 10'h001; b_req = 1; b_we = 0; b_addr = 10'h002;
    for (int i = 0; i < 4; i++) begin
      exp_b = seq[i];
      step();
      chk("t3_addr", ram_addr, exp_b ? 10'h002 : 10'h001);
      chk("t3_busy", busy, 1);
      step();
      chk("t3_aack", a_ack, !exp_b);
      chk("t3_back", b_ack, exp_b);
      chk("t3_data", exp_b ? b_rdata : a_rdata, exp_b ? 32'h22222222 : 32'h11111111);
      step();
      chk("t3_ackoff", a_ack | b_ack, 0);
    end
    a_req = 0;
    step();
    chk("t6_addr", ram_addr, 10'h002);
    step();
    chk("t6_back", b_ack, 1);
    chk("t6_aack", a_ack, 0);
    chk("t6_data", b_rdata, 32'h22222222);
    b_req = 0;
    step();
    // B write/read of a word with the top bit set
    b_req = 1; b_we = 1; b_addr = 10'h155; b_wdata = 32'h80000000;
    step();
    chk("t4_we", ram_we, 1);
    chk("t4_din", ram_din, 32'h80000000);
    step();
    chk("t4_w_ack", b_ack, 1);
    chk("t4_w_rdata", b_rdata, 32'h22222222);
    b_req = 0;
    step();
    b_req = 1; b_we = 0;
    step(); step();
    chk("t4_r_ack", b_ack, 1);
    chk("t4_r_data", b_rdata, 32'h80000000);
    chk("t4_ardata", a_rdata, 32'h11111111);
    chk("t4_aack", a_ack, 0);
    b_req = 0;
    step();
    b_req = 1; b_addr = 10'd5;
    step(); step();
    chk("t1_readback", b_rdata, 0);
    b_req = 0;
    step();
    // A address change during ACCESS is ignored
    a_req = 1; a_we = 0; a_addr = 10'h010;
    step();
    a_addr = 10'h020;
    #5;
    chk("t5_addr", ram_addr, 10'h010);
    @(posedge clk); #1;
    chk("t5_ack", a_ack, 1);
    chk("t5_data", a_rdata, 32'hAAAA0010);
    a_req = 0;
    step();
    chk("t5_busy", busy, 0);
    chk("t5_hold", ram_addr, 10'h010);
    $display("[TB] %0d tests run, %0d failed", n, nf);
    $finish;
  end
endmodule
